// File: rtl/fir_decimator_pkg.sv
// Shared constants for the FIR decimator slice.
// FIR_SAMPLE_W is the sample width produced by the upstream fir stage.
// The DEF_* values are the default block configuration.
package fir_decimator_pkg;

  localparam int FIR_SAMPLE_W   = 16;
  localparam int DEF_OUT_W      = 12;
  localparam int DEF_LOG2_DECIM = 2;
  localparam int DEF_FIFO_DEPTH = 4;

  // The accumulator grows by LOG2_DECIM bits, so the sum of a full block
  // can never wrap.
  function automatic int acc_width(input int in_w, input int log2_decim);
    return in_w + log2_decim;
  endfunction

endpackage

// File: rtl/fir_decimator_sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   push_i, din_i    write request and data (ignored when full unless popping)
//   pop_i            read request (ignored when empty)
//   dout_o           head entry
//   full_o, empty_o  status derived from count
//   count_o          entries held, 0..DEPTH
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic [W-1:0]                 din_i,
  input  logic                         pop_i,
  output logic [W-1:0]                 dout_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // A pop on the same edge frees the slot, so a push into a full FIFO lands.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once count says valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/fir_decimator.sv
// fir_decimator: block-averages 2**LOG2_DECIM valid input samples, saturates
// the average to OUT_W bits and queues it for a valid/ready sink.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   In, in_valid          signed input sample and qualifier
//   Out, out_valid        signed FIFO head (0 when empty), FIFO non-empty
//   out_ready             sink accepts Out this cycle
//   clr_flags             synchronous clear of the sticky flags
//   overflow, sat         sticky: result dropped / result clipped
module fir_decimator
  import fir_decimator_pkg::*;
#(
  parameter int IN_W       = FIR_SAMPLE_W,
  parameter int OUT_W      = DEF_OUT_W,
  parameter int LOG2_DECIM = DEF_LOG2_DECIM,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  In,
  input  logic                    in_valid,
  output logic signed [OUT_W-1:0] Out,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    clr_flags,
  output logic                    overflow,
  output logic                    sat
);

  localparam int ACC_W = acc_width(IN_W, LOG2_DECIM);
  localparam logic [LOG2_DECIM-1:0]  PHASE_LAST = '1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] sum, avg;
  logic [LOG2_DECIM-1:0]   phase_q, phase_d;
  logic signed [OUT_W-1:0] result;
  logic                    clip, push, pop;
  logic                    sat_q, sat_d, ovf_q, ovf_d;
  logic                    fifo_full, fifo_empty;
  logic [OUT_W-1:0]        fifo_dout;
  logic [$clog2(FIFO_DEPTH+1)-1:0] unused_fifo_count;

  assign sum  = acc_q + {{LOG2_DECIM{In[IN_W-1]}}, In};
  // Arithmetic shift floors toward -inf, e.g. -7/4 -> -2.
  assign avg  = sum >>> LOG2_DECIM;
  assign push = in_valid && (phase_q == PHASE_LAST);
  assign pop  = out_valid & out_ready;

  always_comb begin
    clip   = 1'b0;
    result = avg[OUT_W-1:0];
    if (avg > SAT_MAX) begin
      clip   = 1'b1;
      result = SAT_MAX[OUT_W-1:0];
    end else if (avg < SAT_MIN) begin
      clip   = 1'b1;
      result = SAT_MIN[OUT_W-1:0];
    end
  end

  always_comb begin
    acc_d   = acc_q;
    phase_d = phase_q;
    if (in_valid) begin
      if (push) begin
        acc_d   = '0;
        phase_d = '0;
      end else begin
        acc_d   = sum;
        phase_d = phase_q + LOG2_DECIM'(1);
      end
    end
  end

  // A set event on the same edge as clr_flags keeps the flag high.
  assign sat_d = (sat_q & ~clr_flags) | (push & clip);
  assign ovf_d = (ovf_q & ~clr_flags) | (push & fifo_full & ~pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q   <= '0;
      phase_q <= '0;
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      phase_q <= phase_d;
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
    end
  end

  sync_fifo #(
    .W     (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (push),
    .din_i   (result),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (unused_fifo_count)
  );

  assign out_valid = ~fifo_empty;
  assign Out       = fifo_empty ? '0 : $signed(fifo_dout);
  assign sat       = sat_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_fir_decimator.sv
module tb_fir_decimator;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] In;
  logic               in_valid;
  logic signed [11:0] Out;
  logic               out_valid;
  logic               out_ready;
  logic               clr_flags;
  logic               overflow;
  logic               sat;

  fir_decimator dut (
    .clk       (clk),
    .rst       (rst),
    .In        (In),
    .in_valid  (in_valid),
    .Out       (Out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .clr_flags (clr_flags),
    .overflow  (overflow),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int s[4];
    int exp_out;
    int exp_sat;
    bit clr_before;
  } vec_t;

  vec_t tbl[5];
  int   sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: sample at the falling edge (a pop commits on the next rising
  // edge, so the scoreboard compares here), then move to just after the edge.
  task automatic cyc();
    int e;
    @(negedge clk);
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: got Out=%0d, expected no output", int'(Out));
      end else begin
        e = sb.pop_front();
        chk("sb_out", int'(Out), e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input int s[4]);
    for (int i = 0; i < 4; i++) begin
      In       = 16'(s[i]);
      in_valid = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
  endtask

  task automatic clear_flags();
    clr_flags = 1'b1;
    cyc();
    clr_flags = 1'b0;
  endtask

  initial begin
    int blk[4];

    tbl[0] = '{s: '{4, 8, 12, 16},                     exp_out: 10,    exp_sat: 0, clr_before: 1'b0};
    tbl[1] = '{s: '{-1, -2, -2, -2},                   exp_out: -2,    exp_sat: 0, clr_before: 1'b0};
    tbl[2] = '{s: '{1, 1, 1, 0},                       exp_out: 0,     exp_sat: 0, clr_before: 1'b0};
    tbl[3] = '{s: '{32767, 32767, 32767, 32767},       exp_out: 2047,  exp_sat: 1, clr_before: 1'b0};
    tbl[4] = '{s: '{-32768, -32768, -32768, -32768},   exp_out: -2048, exp_sat: 1, clr_before: 1'b1};

    rst       = 1'b0;
    In        = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr_flags = 1'b0;
    #12;
    chk("rst_out", int'(Out), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_sat", int'(sat), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc();

    // Table: averaging, floor rounding, saturation, flag clear.
    out_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      if (tbl[v].clr_before) begin
        clear_flags();
        chk("clr_sat", int'(sat), 0);
      end
      sb.push_back(tbl[v].exp_out);
      send_block(tbl[v].s);
      chk("latency_valid", int'(out_valid), 1);
      cyc();
      chk("one_cycle_valid", int'(out_valid), 0);
      chk("tbl_sat", int'(sat), tbl[v].exp_sat);
      chk("tbl_overflow", int'(overflow), 0);
    end
    chk("tbl_drained", sb.size(), 0);

    // Fill the FIFO with the sink stalled; the fifth result is dropped.
    clear_flags();
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      blk = '{k, k, k, k};
      if (k <= 4) sb.push_back(k);
      send_block(blk);
    end
    chk("full_overflow", int'(overflow), 1);
    chk("full_head", int'(Out), 1);
    cyc();
    chk("hold_head", int'(Out), 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    chk("full_drained", sb.size(), 0);
    chk("empty_after_drain", int'(out_valid), 0);

    // Full FIFO with push and pop on the same edge: no overflow.
    clear_flags();
    out_ready = 1'b0;
    for (int k = 6; k <= 9; k++) begin
      blk = '{k, k, k, k};
      sb.push_back(k);
      send_block(blk);
    end
    for (int i = 0; i < 3; i++) begin
      In       = 16'sd10;
      in_valid = 1'b1;
      cyc();
    end
    sb.push_back(10);
    out_ready = 1'b1;
    cyc();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("pushpop_overflow", int'(overflow), 0);
    chk("pushpop_head", int'(Out), 7);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    chk("pushpop_drained", sb.size(), 0);

    // in_valid on alternate cycles: phase and accumulator hold when idle.
    blk = '{4, 8, 12, 16};
    sb.push_back(10);
    for (int i = 0; i < 4; i++) begin
      In       = 16'(blk[i]);
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      if (i < 3) begin
        In = 16'sh7fff;
        cyc();
        chk("gap_no_valid", int'(out_valid), 0);
      end
    end
    chk("gap_valid", int'(out_valid), 1);
    cyc();
    chk("gap_drained", sb.size(), 0);

    // Reset mid-block with a result queued and flags set.
    out_ready = 1'b0;
    blk = '{32767, 32767, 32767, 32767};
    send_block(blk);
    chk("pre_rst_valid", int'(out_valid), 1);
    In       = 16'sd100;
    in_valid = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    chk("midrst_out", int'(Out), 0);
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_sat", int'(sat), 0);
    chk("midrst_overflow", int'(overflow), 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst       = 1'b1;
    out_ready = 1'b1;
    blk = '{8, 8, 8, 8};
    sb.push_back(8);
    send_block(blk);
    chk("post_rst_valid", int'(out_valid), 1);
    cyc();
    chk("post_rst_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
